dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port. It accepts one load or store per handshake from the datapath (byte address, store data, access size) and services it against a single-port, word-wide synchronous SRAM with one-cycle read latency. Sub-word stores are done as read-modify-write. Load data is returned lane-aligned and zero-extended, so the datapath's existing byte/halfword sign-extension path can consume it directly. While an access is in flight the block drives `stall` to hold the PC.

---
 rtl/dmem_responder.sv | 180 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake against a one-cycle-latency
// word SRAM, with read-modify-write for byte/half stores and lane-aligned load data.
module dmem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state;
  logic              write_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;

  // Handshake: a request is taken on any rising edge where req_valid and
  // req_ready are both high; req_ready is high exactly while the FSM is IDLE,
  // and the request fields are latched on that edge only.
  logic req_err;
  logic req_word_store;
  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  assign req_word_store = req_write & (req_size == 2'b10);

  // Address bits above the SRAM depth alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  logic [4:0]  shamt;
  logic [31:0] load_word;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign shamt     = {lane_q, 3'b000};
  assign load_word = sram_rdata >> shamt;
  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
  assign merged    = (sram_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    load_val = 32'h0;
    case (size_q)
      2'b00:   load_val = {24'h0, load_word[7:0]};
      2'b01:   load_val = {16'h0, load_word[15:0]};
      default: load_val = sram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      waddr_q    <= '0;
      wdata_q    <= 32'h0;
      busy_q     <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            waddr_q   <= req_addr[ADDR_W+1:2];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state      <= S_ISSUE;
              busy_q     <= 1'b1;
              sram_en    <= 1'b1;
              sram_we    <= req_word_store;
              sram_addr  <= req_addr[ADDR_W+1:2];
              sram_wdata <= req_word_store ? req_wdata : 32'h0;
            end
          end
        end
        S_ISSUE: begin
          sram_en    <= 1'b0;
          sram_we    <= 1'b0;
          sram_addr  <= '0;
          sram_wdata <= 32'h0;
          if (write_q && (size_q == 2'b10)) begin
            state     <= S_RESP;
            busy_q    <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (write_q) begin
            state      <= S_WRITE;
            sram_en    <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= waddr_q;
            sram_wdata <= merged;
          end else begin
            state     <= S_RESP;
            busy_q    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_val;
          end
        end
        S_WRITE: begin
          sram_en    <= 1'b0;
          sram_we    <= 1'b0;
          sram_addr  <= '0;
          sram_wdata <= 32'h0;
          busy_q     <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          busy_q     <= 1'b0;
          req_ready  <= 1'b1;
          rsp_valid  <= 1'b0;
          rsp_rdata  <= 32'h0;
          rsp_err    <= 1'b0;
          sram_en    <= 1'b0;
          sram_we    <= 1'b0;
          sram_addr  <= '0;
          sram_wdata <= 32'h0;
        end
      endcase
    end
  end

  // stall drops in RESP so the PC advances on the edge that ends it.
  assign stall     = ((state == S_IDLE) & req_valid) | busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level reference model with its own memory,
// per-cycle output comparison, directed cases with literal results, then random traffic.
module tb_dmem_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic [2:0]        dbg_state;

  dmem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM behavioural model ----------------
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  logic [31:0]       ref_mem [DEPTH];
  logic [32:0]       exp_q[$];
  int                cyc        = 0;
  int                ready_from = 0;
  int                acc_cyc    = -100;
  int                resp_cyc   = -100;
  int                en_a       = -100;
  int                en_b       = -100;
  int                we_cyc     = -100;
  logic [ADDR_W-1:0] exp_addr   = '0;
  logic [31:0]       exp_wdata  = 32'h0;
  bit                acc_pulse  = 1'b0;
  bit                undo_pending = 1'b0;
  int                undo_until = -100;
  logic [ADDR_W-1:0] undo_addr  = '0;
  logic [31:0]       undo_word  = 32'h0;
  int                strobes    = 0;
  int                rsp_count  = 0;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz, input int lane);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    case (sz)
      2'b00:   return {24'h0, b[lane]};
      2'b01:   return {16'h0, b[lane+1], b[lane]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input int lane, input logic [31:0] d);
    logic [7:0] b [4];
    if (sz == 2'b10) return d;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    b[lane] = d[7:0];
    if (sz == 2'b01) b[lane+1] = d[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic model_accept();
    logic [ADDR_W-1:0] wa;
    int          lane;
    bit          err;
    int          lat;
    logic [31:0] old;
    logic [31:0] nw;
    logic [31:0] rd;
    wa   = req_addr[ADDR_W+1:2];
    lane = int'(req_addr[1:0]);
    err  = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
           (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    old  = ref_mem[wa];
    rd   = 32'h0;
    nw   = old;
    if (!err && !req_write) rd = ref_load(old, req_size, lane);
    if (!err && req_write)  nw = ref_store(old, req_size, lane, req_wdata);
    lat = err ? 1 : (!req_write ? 3 : (req_size == 2'b10 ? 2 : 4));
    acc_cyc    = cyc;
    resp_cyc   = cyc + lat - 1;
    ready_from = cyc + lat;
    en_a   = err ? -100 : cyc;
    en_b   = (!err && req_write && req_size != 2'b10) ? cyc + 2 : -100;
    we_cyc = (!err && req_write) ? ((req_size == 2'b10) ? cyc : cyc + 2) : -100;
    exp_addr  = wa;
    exp_wdata = nw;
    exp_q.push_back({err, rd});
    if (!err && req_write) begin
      undo_pending = 1'b1;
      undo_until   = we_cyc;
      undo_addr    = wa;
      undo_word    = old;
      ref_mem[wa]  = nw;
    end else begin
      undo_pending = 1'b0;
    end
    acc_pulse = 1'b1;
  endtask

  // Model advances at each active edge; inputs are stable there.
  always @(posedge clk) begin
    cyc++;
    acc_pulse = 1'b0;
    if (reset === 1'b1 && req_valid === 1'b1 && (cyc - 1) >= ready_from) model_accept();
  end

  // An access killed by reset never lands its write and never responds.
  always @(negedge reset) begin
    if (undo_pending && cyc <= undo_until) ref_mem[undo_addr] = undo_word;
    undo_pending = 1'b0;
    ready_from   = 0;
    acc_cyc      = -100;
    resp_cyc     = -100;
    en_a         = -100;
    en_b         = -100;
    we_cyc       = -100;
    exp_q.delete();
  end

  // ---------------- per-cycle compare ----------------
  int          c_idx;
  bit          c_rst;
  bit          c_ready;
  bit          c_busy;
  bit          c_en;
  bit          c_we;
  bit          c_rsp;
  logic [32:0] c_exp;
  always @(negedge clk) begin
    c_idx   = cyc;
    c_rst   = (reset !== 1'b1);
    c_ready = c_rst || (c_idx >= ready_from);
    c_busy  = !c_rst && (c_idx >= acc_cyc) && (c_idx < resp_cyc);
    c_rsp   = !c_rst && (c_idx == resp_cyc);
    c_en    = !c_rst && (c_idx == en_a || c_idx == en_b);
    c_we    = !c_rst && (c_idx == we_cyc);
    check("req_ready", 32'(req_ready), 32'(c_ready));
    check("stall", 32'(stall), 32'(c_busy || (c_ready && req_valid)));
    check("rsp_valid", 32'(rsp_valid), 32'(c_rsp));
    check("sram_en", 32'(sram_en), 32'(c_en));
    check("sram_we", 32'(sram_we), 32'(c_we));
    check("sram_addr", 32'(sram_addr), c_en ? 32'(exp_addr) : 32'h0);
    check("sram_wdata", sram_wdata, c_we ? exp_wdata : 32'h0);
    if (c_rsp) begin
      if (exp_q.size() == 0) begin
        check("rsp_expected_entry", 32'd0, 32'd1);
      end else begin
        c_exp = exp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(c_exp[32]));
        check("rsp_rdata", rsp_rdata, c_exp[31:0]);
      end
    end else begin
      check("rsp_err_idle", 32'(rsp_err), 32'h0);
      check("rsp_rdata_idle", rsp_rdata, 32'h0);
    end
    if (sram_en === 1'b1) strobes++;
    if (rsp_valid === 1'b1) rsp_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input bit hold);
    bit ok;
    ok        = 1'b0;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (acc_pulse) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 60 cycles");
    end
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
  endtask

  // Directed access with hand-computed latency, data, error and strobe count.
  task automatic dir(input string name, input bit w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input int lat,
                     input logic [31:0] rdata, input bit err, input int nstrobe);
    int  acc_at;
    int  s0;
    bit  got;
    got = 1'b0;
    send(w, sz, a, d, 1'b0);
    acc_at = acc_cyc;
    s0     = strobes;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_latency"}, 32'(cyc - acc_at + 1), 32'(lat));
      check({name, "_rdata"}, rsp_rdata, rdata);
      check({name, "_err"}, 32'(rsp_err), 32'(err));
      check({name, "_strobes"}, 32'(strobes - s0), 32'(nstrobe));
    end
    idle(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    int          acc_at;
    int          r0;
    bit          hold;
    logic [31:0] a;
    logic [1:0]  sz;

    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[4] = 32'h8899AABB;
    ref_mem[4]  = 32'h8899AABB;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    dir("ld_word_10", 1'b0, 2'b10, 32'h10, 32'h0, 3, 32'h8899AABB, 1'b0, 1);
    dir("ld_byte_13", 1'b0, 2'b00, 32'h13, 32'h0, 3, 32'h00000088, 1'b0, 1);
    dir("ld_half_12", 1'b0, 2'b01, 32'h12, 32'h0, 3, 32'h00008899, 1'b0, 1);
    dir("ld_byte_10", 1'b0, 2'b00, 32'h10, 32'h0, 3, 32'h000000BB, 1'b0, 1);
    dir("st_byte_11", 1'b1, 2'b00, 32'h11, 32'hFFFFFFCC, 4, 32'h0, 1'b0, 2);
    dir("ld_after_sb", 1'b0, 2'b10, 32'h10, 32'h0, 3, 32'h8899CCBB, 1'b0, 1);
    dir("st_word_14", 1'b1, 2'b10, 32'h14, 32'h12345678, 2, 32'h0, 1'b0, 1);
    dir("st_half_16", 1'b1, 2'b01, 32'h16, 32'h0000BEEF, 4, 32'h0, 1'b0, 2);
    dir("ld_after_sh", 1'b0, 2'b10, 32'h14, 32'h0, 3, 32'hBEEF5678, 1'b0, 1);
    dir("err_half_11", 1'b0, 2'b01, 32'h11, 32'h0, 1, 32'h0, 1'b1, 0);
    dir("err_word_12", 1'b1, 2'b10, 32'h12, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0);
    dir("err_size_11", 1'b0, 2'b11, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);

    // Reset during the write phase of a byte store must abort it.
    dir("st_word_20", 1'b1, 2'b10, 32'h20, 32'h11223344, 2, 32'h0, 1'b0, 1);
    send(1'b1, 2'b00, 32'h21, 32'h000000AA, 1'b0);
    acc_at = acc_cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc == acc_at + 2) break;
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_sram_en", 32'(sram_en), 32'd0);
    check("abort_sram_we", 32'(sram_we), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    check("abort_req_ready_after", 32'(req_ready), 32'd1);
    dir("ld_after_abort", 1'b0, 2'b10, 32'h20, 32'h0, 3, 32'h11223344, 1'b0, 1);

    // Back-to-back loads with req_valid held across RESP.
    r0 = rsp_count;
    send(1'b0, 2'b10, 32'h10, 32'h0, 1'b1);
    send(1'b0, 2'b00, 32'h13, 32'h0, 1'b1);
    send(1'b0, 2'b01, 32'h16, 32'h0, 1'b0);
    idle(12);
    check("b2b_rsp_count", 32'(rsp_count - r0), 32'd3);

    // Random traffic over a small word window with aliasing upper bits.
    for (int n = 0; n < 400; n++) begin
      v    = $urandom;
      a    = (v & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      hold = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), sz, a, $urandom, hold);
      if (!hold) idle($urandom_range(0, 2));
    end
    req_valid = 1'b0;
    idle(10);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
